fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined core.
- Holds its own shift register of in-flight register writers for the stages after EX, so callers no longer route per-stage rd/RegWrite/MemToReg wires.
- Generalised over source count, forwarding depth and load-data latency.
- Generates per-source bypass selects, a load-use stall request with automatic bubble insertion, and a late store-data bypass flag; it also counts stall cycles.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of EX source operands; channel 0 = rs, channel 1 = rt/store data.
- FWD_DEPTH, 2, tracked stages after EX; stage 1 = MEM, stage FWD_DEPTH = last stage before the regfile write is visible.
- LOAD_STAGE, 2, first stage index at which load data is forwardable. Range 1..FWD_DEPTH.
- CNT_W, 16, width of the stall cycle counter.
- SEL_W, $clog2(FWD_DEPTH+1), derived width of each forward select.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- adv  input  1  pipeline advance. It is 0 when an external stall freezes EX and later stages.
- ex_valid  input  1  EX holds a real instruction.
- ex_flush  input  1  EX instruction is being killed this cycle.
- ex_rd  input  REG_AW  EX destination register.
- ex_reg_write  input  1  EX instruction writes the regfile.
- ex_is_load  input  1  EX instruction is a load.
- ex_mem_write  input  1  EX instruction is a store; its data is on channel 1.
- ex_src  input  NUM_SRC*REG_AW  packed EX source registers; channel j is at bits [j*REG_AW +: REG_AW].
- fwd_sel  output  NUM_SRC*SEL_W  per-channel select. 0 = regfile/ID value; k = result of stage k.
- stall_req  output  1  hold IF/ID/EX this cycle.
- wd_late  output  1  the store data must be bypassed in MEM from stage LOAD_STAGE.
- stall_cycles  output  CNT_W  saturating count of cycles with stall_req=1.

Behaviour:
- State for each stage k in 1..FWD_DEPTH: v[k], rd[k], ld[k].

Reset:
- rst_n low clears all v[k] and stall_cycles asynchronously.
- With v all clear, fwd_sel=0, stall_req=0 and wd_late=0 immediately.

Stage entry:
- ins = ex_valid & ~ex_flush & ex_reg_write & (ex_rd != 0).
- An entry with rd = 0 is never created, so r0 is never forwarded.

Match per channel j:
- Candidates are stages k with v[k] & (rd[k] == src_j) & (src_j != 0).
- The youngest stage (lowest k) wins; older duplicate writers are ignored.

Hazard per channel j, with youngest match k:
- If ld[k] and k < LOAD_STAGE, the channel is a hazard, with one exception.
- Exception: j==1, ex_mem_write, ld[k], and k == LOAD_STAGE-1. Then there is no hazard, wd_late=1 and fwd_sel[1]=0.
- Otherwise fwd_sel[j]=k.
- A hazard channel outputs fwd_sel[j]=0.

stall_req:
- stall_req = ex_valid & ~ex_flush & (OR of hazard over all channels).
- Combinational from state and EX inputs; zero added latency.

Clock edge, adv=1, stall_req=0:
- Stage 1 takes {ins, ex_rd, ex_is_load}.
- Each stage k>1 takes stage k-1.
- Stage FWD_DEPTH drops out.

Clock edge, adv=1, stall_req=1:
- The stages shift as above, but stage 1 takes a bubble (v=0).
- EX is held externally, so the same instruction is re-evaluated next cycle.
- Stall length is therefore LOAD_STAGE-1-k+1 cycles, which needs no counter.

Clock edge, adv=0:
- All stages hold.
- stall_cycles does not increment.

stall_cycles:
- Increments on each edge with adv & stall_req.
- Saturates at all-ones.

Simultaneous events:
- ex_flush with a hazard: flush wins, stall_req=0, and a bubble enters stage 1.
- Reset mid-stall: all state clears and stall_req drops asynchronously.

Test Plan:
(Defaults unless stated.)
- ALU forwarding: cycle 0 EX add r3 (ins=1), adv=1; cycle 1 ex_src0=r3 -> fwd_sel[0]=1, stall_req=0.
- Youngest wins: r3 writers in stage 1 and stage 2, ex_src1=r3 -> fwd_sel[1]=1. With only stage 2 holding r3 -> fwd_sel[1]=2.
- Load-use, with the store exception checked first: EX lw r5; next EX add with src0=r5, not a store.
  - Cycle 1: stall_req=1, fwd_sel[0]=0.
  - Cycle 2: stage 1 is a bubble, fwd_sel[0]=2, stall_req=0.
  - stall_cycles=1.
- Store after load: lw r5, then sw with ex_mem_write=1 and src1=r5 -> stall_req=0, wd_late=1, fwd_sel[1]=0.
  - Same sequence with src0=r5 (the address operand) -> stall_req=1.
- r0 and flush:
  - add r0 followed by src0=r0 -> fwd_sel=0.
  - ex_flush=1 on the lw cycle -> the next use of r5 sees no match.
  - ex_flush asserted during a stall -> stall_req=0.
- Depth generalisation, FWD_DEPTH=3 and LOAD_STAGE=3: lw r7 then a use of r7 -> stall_req high for 2 cycles, then fwd_sel=3, stall_cycles=2.
- Hold and reset:
  - adv=0 for 3 cycles -> fwd_sel stable and stall_cycles unchanged.
  - rst_n pulsed low mid-stall -> stall_req=0, fwd_sel=0 and stall_cycles=0 within the same cycle.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Bundle between the EX stage of the core and the forwarding/hazard scoreboard.
// The pipeline side is the master; the scoreboard is the slave.
interface fwd_scoreboard_if #(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
);
    logic                      adv;
    logic                      ex_valid;
    logic                      ex_flush;
    logic [REG_AW-1:0]         ex_rd;
    logic                      ex_reg_write;
    logic                      ex_is_load;
    logic                      ex_mem_write;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic                      stall_req;
    logic                      wd_late;
    logic [CNT_W-1:0]          stall_cycles;

    modport master (
        output adv, ex_valid, ex_flush, ex_rd, ex_reg_write, ex_is_load, ex_mem_write, ex_src,
        input  fwd_sel, stall_req, wd_late, stall_cycles
    );

    modport slave (
        input  adv, ex_valid, ex_flush, ex_rd, ex_reg_write, ex_is_load, ex_mem_write, ex_src,
        output fwd_sel, stall_req, wd_late, stall_cycles
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit: tracks in-flight register writers after EX
// and produces bypass selects, a stall request with bubble insertion and a stall counter.
module fwd_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_scoreboard_if.slave sb
);

    logic [FWD_DEPTH:1]  stgV;
    logic [FWD_DEPTH:1]  stgLd;
    logic [REG_AW-1:0]   stgRd [1:FWD_DEPTH];
    logic [CNT_W-1:0]    stallCnt;

    logic                     ins;
    logic                     stall;
    logic [NUM_SRC-1:0]       hazard;
    logic [NUM_SRC-1:0]       late;
    logic [NUM_SRC*SEL_W-1:0] selBus;

    // r0 writers never enter the tracker, so r0 can never be forwarded.
    assign ins = sb.ex_valid & ~sb.ex_flush & sb.ex_reg_write & (sb.ex_rd != '0);

    always_comb begin
        logic              hit;
        logic              hitLd;
        logic [SEL_W-1:0]  hitStg;
        logic [REG_AW-1:0] src;
        // NOTE: every comb output gets a default before any conditional write, so no latch is inferred.
        hazard = '0;
        late   = '0;
        selBus = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            hit    = 1'b0;
            hitLd  = 1'b0;
            hitStg = '0;
            src    = sb.ex_src[j*REG_AW +: REG_AW];
            // Scan oldest to youngest so the youngest matching stage overrides.
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (stgV[k] && (stgRd[k] == src) && (src != '0)) begin
                    hit    = 1'b1;
                    hitLd  = stgLd[k];
                    hitStg = SEL_W'(k);
                end
            end
            // Store data one stage short of the load result is picked up late in MEM.
            late[j]   = (j == 1) && sb.ex_mem_write && hit && hitLd
                        && (int'(hitStg) == LOAD_STAGE - 1);
            hazard[j] = hit && hitLd && (int'(hitStg) < LOAD_STAGE) && !late[j];
            if (hit && !hazard[j] && !late[j])
                selBus[j*SEL_W +: SEL_W] = hitStg;
        end
    end

    assign stall = sb.ex_valid & ~sb.ex_flush & (|hazard);

    assign sb.fwd_sel      = selBus;
    assign sb.stall_req    = stall;
    assign sb.wd_late      = |late;
    assign sb.stall_cycles = stallCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stgV     <= '0;
            stallCnt <= '0;
        end else if (sb.adv) begin
            // NOTE: non-blocking assignments let each stage sample its predecessor's pre-edge value.
            stgV[1] <= ins & ~stall;
            for (int k = 2; k <= FWD_DEPTH; k++)
                stgV[k] <= stgV[k-1];
            if (stall && !(&stallCnt))
                stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    // NOTE: rd/ld are only ever read qualified by their valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (sb.adv) begin
            stgRd[1] <= sb.ex_rd;
            stgLd[1] <= sb.ex_is_load;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                stgRd[k] <= stgRd[k-1];
                stgLd[k] <= stgLd[k-1];
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default instance A and a deeper instance B
// (FWD_DEPTH=3, LOAD_STAGE=3) sharing clock and reset.
module tb_fwd_scoreboard;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErrors;

    fwd_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(16)) busA ();
    fwd_scoreboard_if #(.REG_AW(5), .NUM_SRC(2), .SEL_W(2), .CNT_W(16)) busB ();

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_STAGE(2), .CNT_W(16))
        dutA (.clk(clk), .rst_n(rst_n), .sb(busA));

    fwd_scoreboard #(.REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_STAGE(3), .CNT_W(16))
        dutB (.clk(clk), .rst_n(rst_n), .sb(busB));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveA(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                          input logic mw, input logic [4:0] s0, input logic [4:0] s1);
        busA.ex_valid     = v;
        busA.ex_flush     = 1'b0;
        busA.ex_rd        = rd;
        busA.ex_reg_write = rw;
        busA.ex_is_load   = ld;
        busA.ex_mem_write = mw;
        busA.ex_src       = {s1, s0};
    endtask

    task automatic clearA();
        busA.adv = 1'b1;
        driveA(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        busA.adv = 1'b1;
        busB.adv = 1'b1;
        busB.ex_valid = 1'b0; busB.ex_flush = 1'b0; busB.ex_rd = '0; busB.ex_reg_write = 1'b0;
        busB.ex_is_load = 1'b0; busB.ex_mem_write = 1'b0; busB.ex_src = '0;
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd5);
        #2;
        nChecks++;
        if (busA.fwd_sel !== 4'd0 || busA.stall_req !== 1'b0 || busA.wd_late !== 1'b0) begin
            nErrors++;
            $display("FAIL reset_outputs: fwd_sel=%0h stall=%0b wd_late=%0b, required 0/0/0",
                     busA.fwd_sel, busA.stall_req, busA.wd_late);
        end
        nChecks++;
        if (busA.stall_cycles !== 16'd0) begin
            nErrors++;
            $display("FAIL reset_count: stall_cycles=%0d, required 0", busA.stall_cycles);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_alu_fwd();
        clearA();
        driveA(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd0);
        #1;
        nChecks++;
        if (busA.fwd_sel[1:0] !== 2'd1 || busA.stall_req !== 1'b0) begin
            nErrors++;
            $display("FAIL alu_fwd_stage1: sel0=%0d stall=%0b, required 1/0",
                     busA.fwd_sel[1:0], busA.stall_req);
        end
        tick();
        nChecks++;
        if (busA.fwd_sel[1:0] !== 2'd2) begin
            nErrors++;
            $display("FAIL alu_fwd_stage2: sel0=%0d, required 2", busA.fwd_sel[1:0]);
        end
    endtask

    task automatic test_youngest();
        clearA();
        driveA(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3);
        #1;
        nChecks++;
        if (busA.fwd_sel[3:2] !== 2'd1) begin
            nErrors++;
            $display("FAIL youngest_wins: sel1=%0d, required 1", busA.fwd_sel[3:2]);
        end
        tick();
        nChecks++;
        if (busA.fwd_sel[3:2] !== 2'd2) begin
            nErrors++;
            $display("FAIL older_only: sel1=%0d, required 2", busA.fwd_sel[3:2]);
        end
    endtask

    task automatic test_store_late();
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd5);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b0 || busA.wd_late !== 1'b1 || busA.fwd_sel !== 4'd0) begin
            nErrors++;
            $display("FAIL store_late: stall=%0b wd_late=%0b fwd_sel=%0h, required 0/1/0",
                     busA.stall_req, busA.wd_late, busA.fwd_sel);
        end
        tick();
        nChecks++;
        if (busA.stall_cycles !== 16'd0 || busA.wd_late !== 1'b0 || busA.fwd_sel[3:2] !== 2'd2) begin
            nErrors++;
            $display("FAIL store_late_after: count=%0d wd_late=%0b sel1=%0d, required 0/0/2",
                     busA.stall_cycles, busA.wd_late, busA.fwd_sel[3:2]);
        end
    endtask

    task automatic test_load_use();
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b1 || busA.fwd_sel[1:0] !== 2'd0) begin
            nErrors++;
            $display("FAIL load_use_stall: stall=%0b sel0=%0d, required 1/0",
                     busA.stall_req, busA.fwd_sel[1:0]);
        end
        tick();
        nChecks++;
        if (busA.stall_req !== 1'b0 || busA.fwd_sel[1:0] !== 2'd2 || busA.stall_cycles !== 16'd1) begin
            nErrors++;
            $display("FAIL load_use_release: stall=%0b sel0=%0d count=%0d, required 0/2/1",
                     busA.stall_req, busA.fwd_sel[1:0], busA.stall_cycles);
        end
    endtask

    task automatic test_store_addr();
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b1 || busA.wd_late !== 1'b0) begin
            nErrors++;
            $display("FAIL store_addr_stall: stall=%0b wd_late=%0b, required 1/0",
                     busA.stall_req, busA.wd_late);
        end
        tick();
        nChecks++;
        if (busA.stall_req !== 1'b0 || busA.fwd_sel[1:0] !== 2'd2 || busA.stall_cycles !== 16'd2) begin
            nErrors++;
            $display("FAIL store_addr_release: stall=%0b sel0=%0d count=%0d, required 0/2/2",
                     busA.stall_req, busA.fwd_sel[1:0], busA.stall_cycles);
        end
    endtask

    task automatic test_r0_flush();
        clearA();
        driveA(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        nChecks++;
        if (busA.fwd_sel !== 4'd0) begin
            nErrors++;
            $display("FAIL r0_no_fwd: fwd_sel=%0h, required 0", busA.fwd_sel);
        end
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        busA.ex_flush = 1'b1;
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
        #1;
        nChecks++;
        if (busA.fwd_sel[1:0] !== 2'd0 || busA.stall_req !== 1'b0) begin
            nErrors++;
            $display("FAIL flushed_load: sel0=%0d stall=%0b, required 0/0",
                     busA.fwd_sel[1:0], busA.stall_req);
        end
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b1) begin
            nErrors++;
            $display("FAIL flush_pre_stall: stall=%0b, required 1", busA.stall_req);
        end
        busA.ex_flush = 1'b1;
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b0) begin
            nErrors++;
            $display("FAIL flush_wins: stall=%0b, required 0", busA.stall_req);
        end
        tick();
        nChecks++;
        if (busA.stall_cycles !== 16'd2) begin
            nErrors++;
            $display("FAIL flush_no_count: count=%0d, required 2", busA.stall_cycles);
        end
    endtask

    task automatic test_hold();
        clearA();
        driveA(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd3);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b1 || busA.fwd_sel !== {2'd2, 2'd0}) begin
            nErrors++;
            $display("FAIL hold_entry: stall=%0b fwd_sel=%0h, required 1/8",
                     busA.stall_req, busA.fwd_sel);
        end
        busA.adv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (busA.stall_req !== 1'b1 || busA.fwd_sel !== {2'd2, 2'd0} || busA.stall_cycles !== 16'd2) begin
                nErrors++;
                $display("FAIL hold_cycle%0d: stall=%0b fwd_sel=%0h count=%0d, required 1/8/2",
                         i, busA.stall_req, busA.fwd_sel, busA.stall_cycles);
            end
        end
        busA.adv = 1'b1;
        tick();
        nChecks++;
        if (busA.stall_req !== 1'b0 || busA.fwd_sel !== {2'd0, 2'd2} || busA.stall_cycles !== 16'd3) begin
            nErrors++;
            $display("FAIL hold_release: stall=%0b fwd_sel=%0h count=%0d, required 0/2/3",
                     busA.stall_req, busA.fwd_sel, busA.stall_cycles);
        end
    endtask

    task automatic test_reset_mid_stall();
        clearA();
        driveA(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        driveA(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0);
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b1) begin
            nErrors++;
            $display("FAIL mid_stall_pre: stall=%0b, required 1", busA.stall_req);
        end
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (busA.stall_req !== 1'b0 || busA.fwd_sel !== 4'd0 || busA.stall_cycles !== 16'd0) begin
            nErrors++;
            $display("FAIL mid_stall_reset: stall=%0b fwd_sel=%0h count=%0d, required 0/0/0",
                     busA.stall_req, busA.fwd_sel, busA.stall_cycles);
        end
        tick();
        rst_n = 1'b1;
        clearA();
    endtask

    task automatic test_depth();
        busB.adv = 1'b1;
        busB.ex_valid = 1'b1; busB.ex_flush = 1'b0; busB.ex_rd = 5'd7; busB.ex_reg_write = 1'b1;
        busB.ex_is_load = 1'b1; busB.ex_mem_write = 1'b0; busB.ex_src = '0;
        tick();
        busB.ex_rd = 5'd8; busB.ex_is_load = 1'b0; busB.ex_src = {5'd0, 5'd7};
        #1;
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (busB.stall_req !== 1'b1) begin
                nErrors++;
                $display("FAIL depth_stall%0d: stall=%0b, required 1", i, busB.stall_req);
            end
            tick();
        end
        nChecks++;
        if (busB.stall_req !== 1'b0 || busB.fwd_sel[1:0] !== 2'd3 || busB.stall_cycles !== 16'd2) begin
            nErrors++;
            $display("FAIL depth_release: stall=%0b sel0=%0d count=%0d, required 0/3/2",
                     busB.stall_req, busB.fwd_sel[1:0], busB.stall_cycles);
        end
        busB.ex_valid = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        test_reset();
        test_alu_fwd();
        test_youngest();
        test_store_late();
        test_load_use();
        test_store_addr();
        test_r0_flush();
        test_hold();
        test_reset_mid_stall();
        test_depth();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
